// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: BCD mm:ss.cc counter advanced by a 100 Hz tick, with a
// start/stop/split/clear state machine and a live/split display mux.
module stopwatch_ctrl #(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lapped,
  output logic        overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StSplit, StPause} state_e;

  localparam logic [3:0] MinTens = 4'(MIN_MAX / 10);
  localparam logic [3:0] MinOnes = 4'(MIN_MAX % 10);

  state_e          state_q, state_d;
  // Digit index 0 is cs_ones, 5 is min_tens; packing matches disp_bcd order.
  logic [5:0][3:0] cnt_q, cnt_d, cnt_inc;
  logic [5:0][3:0] split_q, split_d;
  logic            overflow_q, overflow_d;
  logic            cnt_en, at_max, carry;

  assign cnt_en = tick && (state_q == StRun || state_q == StSplit);
  assign at_max = (cnt_q[5] == MinTens) && (cnt_q[4] == MinOnes) && (cnt_q[3] == 4'd5) &&
                  (cnt_q[2] == 4'd9) && (cnt_q[1] == 4'd9) && (cnt_q[0] == 4'd9);

  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt_q[i] == ((i == 3) ? 4'd5 : 4'd9)) begin
          cnt_inc[i] = 4'd0;
        end else begin
          cnt_inc[i] = cnt_q[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    // Minutes never exceed MIN_MAX here: that case is the wrap below.
    if (carry) begin
      if (cnt_q[4] == 4'd9) begin
        cnt_inc[4] = 4'd0;
        cnt_inc[5] = cnt_q[5] + 4'd1;
      end else begin
        cnt_inc[4] = cnt_q[4] + 4'd1;
      end
    end
    if (at_max) cnt_inc = '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_en ? cnt_inc : cnt_q;
    split_d    = split_q;
    overflow_d = cnt_en && at_max;
    case (state_q)
      StIdle: begin
        if (start_stop) state_d = StRun;
      end
      StRun: begin
        if (start_stop) begin
          state_d = StPause;
        end else if (lap) begin
          state_d = StSplit;
          split_d = cnt_d;
        end
      end
      StSplit: begin
        if (start_stop)  state_d = StPause;
        else if (lap)    state_d = StRun;
      end
      StPause: begin
        if (clear) begin
          state_d = StIdle;
          cnt_d   = '0;
          split_d = '0;
        end else if (start_stop) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      split_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      split_q    <= split_d;
      overflow_q <= overflow_d;
    end
  end

  assign disp_bcd = (state_q == StSplit) ? split_q : cnt_q;
  assign running  = (state_q == StRun) || (state_q == StSplit);
  assign lapped   = (state_q == StSplit);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl; a second instance with MIN_MAX=1 reaches the wrap cheaply.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        tick = 1'b0, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [23:0] disp0, disp1;
  logic        run0, run1, lapd0, lapd1, ovf0, ovf1;
  logic [26:0] obs0, obs1, e;
  logic [26:0] sb[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MIN_MAX(59)) u_dut0 (
    .clk(clk), .rstn(rstn), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp_bcd(disp0), .running(run0), .lapped(lapd0), .overflow(ovf0)
  );

  stopwatch_ctrl #(.MIN_MAX(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp_bcd(disp1), .running(run1), .lapped(lapd1), .overflow(ovf1)
  );

  // Observation word: {disp_bcd, running, lapped, overflow}
  assign obs0 = {disp0, run0, lapd0, ovf0};
  assign obs1 = {disp1, run1, lapd1, ovf1};

  task automatic cyc(input logic t, input logic ss, input logic lp, input logic cl);
    @(negedge clk);
    tick = t; start_stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    sb.push_back({24'h000000, 3'b000});
    sb.push_back({24'h000000, 3'b000});
    repeat (2) @(negedge clk);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL reset_dut0 got=%h exp=%h", obs0, e); end
    e = sb.pop_front(); total++;
    if (obs1 !== e) begin bad++; $display("FAIL reset_dut1 got=%h exp=%h", obs1, e); end
    rstn = 1'b1;
  endtask

  task automatic test_count();
    apply_reset();
    sb.push_back({24'h000000, 3'b100});
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL start_tick_ignored got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000150, 3'b100});
    ticks(150);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL count_150 got=%h exp=%h", obs0, e); end
  endtask

  task automatic test_split();
    apply_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(999);
    sb.push_back({24'h000999, 3'b100});
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL run_9_99 got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000999, 3'b110});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL split_enter got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000999, 3'b110});
    ticks(25);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL split_frozen got=%h exp=%h", obs0, e); end
    sb.push_back({24'h001024, 3'b100});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL split_release got=%h exp=%h", obs0, e); end
    // Lap with a coincident tick captures the incremented value.
    sb.push_back({24'h001025, 3'b110});
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL split_with_tick got=%h exp=%h", obs0, e); end
    ticks(1);
    sb.push_back({24'h001026, 3'b000});
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL split_to_pause got=%h exp=%h", obs0, e); end
  endtask

  task automatic test_pause_clear();
    apply_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(500);
    sb.push_back({24'h000501, 3'b000});
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL pause_tick_counted got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000501, 3'b000});
    ticks(10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL pause_hold got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000000, 3'b000});
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(4);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL clear_idle got=%h exp=%h", obs0, e); end
  endtask

  task automatic test_overflow();
    apply_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(11998);
    sb.push_back({24'h015998, 3'b100});
    e = sb.pop_front(); total++;
    if (obs1 !== e) begin bad++; $display("FAIL preload_1_59_98 got=%h exp=%h", obs1, e); end
    sb.push_back({24'h015999, 3'b100});
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs1 !== e) begin bad++; $display("FAIL max_1_59_99 got=%h exp=%h", obs1, e); end
    sb.push_back({24'h000000, 3'b101});
    sb.push_back({24'h020000, 3'b100});
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs1 !== e) begin bad++; $display("FAIL wrap_pulse got=%h exp=%h", obs1, e); end
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL minute_carry got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000000, 3'b100});
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); total++;
    if (obs1 !== e) begin bad++; $display("FAIL wrap_pulse_end got=%h exp=%h", obs1, e); end
    sb.push_back({24'h000001, 3'b100});
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs1 !== e) begin bad++; $display("FAIL post_wrap_count got=%h exp=%h", obs1, e); end
  endtask

  task automatic test_priority();
    apply_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    sb.push_back({24'h000006, 3'b000});
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL run_all_buttons got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000000, 3'b000});
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    ticks(3);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL pause_clear_wins got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000001, 3'b100});
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(1);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL restart_from_idle got=%h exp=%h", obs0, e); end
  endtask

  task automatic test_reset_mid_split();
    apply_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(6234);
    sb.push_back({24'h010234, 3'b110});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL split_1_02_34 got=%h exp=%h", obs0, e); end
    // Assert reset between edges: outputs must clear without a clock.
    sb.push_back({24'h000000, 3'b000});
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs0, e); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    sb.push_back({24'h000000, 3'b000});
    ticks(5);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL idle_after_reset got=%h exp=%h", obs0, e); end
    sb.push_back({24'h000003, 3'b100});
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    e = sb.pop_front(); total++;
    if (obs0 !== e) begin bad++; $display("FAIL resume_after_reset got=%h exp=%h", obs0, e); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_split();
    test_pause_clear();
    test_overflow();
    test_priority();
    test_reset_mid_split();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
